interrupt_ctrl: RTL
===================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5, meaning number of interrupt sources, legal 1..8.
REQ-002 SHALL have parameter IF_ADDR, default 16'hFF0F, meaning flag register address.
REQ-003 SHALL have parameter IE_ADDR, default 16'hFFFF, meaning enable register address.
REQ-004 SHALL have parameter VEC_BASE, default 16'h0040, meaning vector of source 0; vector stride is 8.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state is on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset (asserted at 0).
REQ-007 SHALL have port addr, input, 16, meaning CPU bus address.
REQ-008 SHALL have port wdata, input, 8, meaning CPU write data.
REQ-009 SHALL have port read_en, input, 1, meaning CPU read strobe.
REQ-010 SHALL have port write_en, input, 1, meaning CPU write strobe.
REQ-011 SHALL have port rdata, output, 8, meaning read data.
REQ-012 SHALL have port src_req, input, NUM_SRC, meaning hardware request per source; bit 0 is highest priority.
REQ-013 SHALL have port irq_valid, output, 1, meaning an enabled flag is pending.
REQ-014 SHALL have port irq_id, output, 3, meaning index of highest-priority pending source.
REQ-015 SHALL have port irq_vec, output, 16, meaning VEC_BASE + 8*irq_id.
REQ-016 SHALL have port irq_ack, input, 1, meaning one-cycle CPU acknowledge of the presented irq_id.

Function
REQ-017 SHALL hold IF (NUM_SRC bits) and IE (8 bits) registers.
REQ-018 SHALL read IF as IF with bits NUM_SRC..7 forced to 1; IE reads the full stored byte.
REQ-019 SHALL drive rdata combinationally: IF value when addr==IF_ADDR, IE when addr==IE_ADDR, else 8'h00.
REQ-020 SHALL compute next IF = ((write to IF ? wdata[NUM_SRC-1:0] : IF) & ~ack_mask) | set_mask.
REQ-021 SHALL make a hardware set win over a CPU write or an ack of the same bit in the same cycle.
REQ-022 SHALL write IE with all 8 bits of wdata on write_en at IE_ADDR.
REQ-023 SHALL compute pending = IF & IE[NUM_SRC-1:0]; lowest set index wins.
REQ-024 SHALL register irq_valid/irq_id/irq_vec, so outputs reflect IF/IE one cycle after they change.
REQ-025 SHALL implement states IDLE (irq_valid=0), PEND (irq_valid=1), BLANK; IDLE->PEND when pending nonzero; PEND->IDLE when pending clears without ack; PEND->BLANK on irq_ack; BLANK->IDLE or PEND next cycle.
REQ-026 SHALL, on irq_ack in PEND, clear exactly the IF bit of the presented irq_id; ack_mask is 0 otherwise.
REQ-027 SHALL ignore irq_ack in IDLE or BLANK.
REQ-028 SHALL keep irq_valid=0 in BLANK so a stale id is never presented twice.
REQ-029 SHALL let a higher-priority arrival in PEND update irq_id on the next cycle without leaving PEND.

Reset
REQ-030 SHALL, while reset=0, force IF=0, IE=8'h00, state=IDLE, irq_valid=0, irq_id=0, irq_vec=VEC_BASE, edge history=0.
REQ-031 SHALL abandon any in-flight ack on reset; first possible irq_valid is two cycles after release with a source held high.

Configuration
REQ-032 SHALL, with IRQ_EDGE_DETECT_EN defined, set an IF bit only on a 0->1 transition of src_req (previous-cycle register per source).
REQ-033 SHALL, without IRQ_EDGE_DETECT_EN, set an IF bit every cycle src_req is 1 (level mode).

Structure
REQ-034 SHALL take IF/IE default addresses, VEC_BASE, vector stride and a source-index enum (VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4) from shared package irq_pkg.
REQ-035 SHALL place the priority encoder in sub-module irq_prio_enc (NUM_SRC in, valid + 3-bit index out).

Verification
REQ-036 SHALL cover: IE=8'h1F, pulse src_req[2] -> IF reads 8'hE4, irq_valid=1, irq_id=2, irq_vec=16'h0050 one cycle later.
REQ-037 SHALL cover: src_req[4] and src_req[0] together, IE=8'h1F -> irq_id=0; ack -> BLANK cycle, then irq_id=4, irq_vec=16'h0060.
REQ-038 SHALL cover: CPU writes 8'h00 to FF0F while src_req[1] rises -> IF reads 8'hE2.
REQ-039 SHALL cover: IE=8'h00, src_req[3] -> IF bit 3 set, irq_valid stays 0; writing IE=8'h08 -> irq_valid=1 next cycle.
REQ-040 SHALL cover: src_req[0] held high 4 cycles, ack after first -> IRQ_EDGE_DETECT_EN: IF[0]=0 after ack; level mode: IF[0] re-sets.
REQ-041 SHALL cover: reset=0 asserted in PEND mid-ack -> all outputs at reset values that same cycle, IF reads 8'hE0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared interrupt-controller definitions: default register addresses, vector layout,
// source indices and FSM state encoding.
package irq_pkg;

    localparam logic [15:0] IF_ADDR_DEF  = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEF  = 16'hFFFF;
    localparam logic [15:0] VEC_BASE_DEF = 16'h0040;
    localparam int          VEC_STRIDE   = 8;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_src_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } irq_state_e;

    function automatic logic [15:0] vec_of(input logic [15:0] base, input logic [2:0] id);
        return base + 16'(id) * 16'(VEC_STRIDE);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc #(
    parameter int NUM_SRC = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [2:0]         idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Scan from the top so the lowest index is written last and wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller with IF/IE registers, fixed priority and an ack/blank handshake.
// Define IRQ_EDGE_DETECT_EN to set flags on rising src_req edges instead of level.
module interrupt_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_SRC  = 5,
    parameter logic [15:0] IF_ADDR  = IF_ADDR_DEF,
    parameter logic [15:0] IE_ADDR  = IE_ADDR_DEF,
    parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        addr,
    input  logic [7:0]         wdata,
    input  logic               read_en,
    input  logic               write_en,
    output logic [7:0]         rdata,
    input  logic [NUM_SRC-1:0] src_req,
    output logic               irq_valid,
    output logic [2:0]         irq_id,
    output logic [15:0]        irq_vec,
    input  logic               irq_ack
);

    logic [NUM_SRC-1:0] if_reg;
    logic [NUM_SRC-1:0] if_next;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] ack_mask;
    logic [NUM_SRC-1:0] pending;
    logic [7:0]         ie_reg;
    logic [7:0]         if_read;
    irq_state_e         state_reg;
    irq_state_e         state_next;
    logic               irq_valid_reg;
    logic [2:0]         irq_id_reg;
    logic [15:0]        irq_vec_reg;
    logic               enc_valid;
    logic [2:0]         enc_idx;
    logic               wr_if;
    logic               wr_ie;
    logic               ack_hit;

    // Reads have no side effects, so the read strobe is not needed.
    logic unused_read_en;
    assign unused_read_en = read_en;

    assign wr_if   = write_en && (addr == IF_ADDR);
    assign wr_ie   = write_en && (addr == IE_ADDR);
    assign ack_hit = (state_reg == PEND) && irq_ack;
    assign pending = if_reg & ie_reg[NUM_SRC-1:0];

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] src_prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_prev_reg <= '0;
        end else begin
            src_prev_reg <= src_req;
        end
    end

    assign set_mask = src_req & ~src_prev_reg;
`else
    assign set_mask = src_req;
`endif

    // Only the id actually presented to the CPU is cleared by an ack.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ack
            assign ack_mask[gi] = ack_hit && (irq_id_reg == 3'(gi));
        end
    endgenerate

    assign if_next = ((wr_if ? wdata[NUM_SRC-1:0] : if_reg) & ~ack_mask) | set_mask;

    // Unimplemented flag bits read back as ones.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_if_read
            if (gi < NUM_SRC) begin : g_live
                assign if_read[gi] = if_reg[gi];
            end else begin : g_pad
                assign if_read[gi] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        rdata = 8'h00;
        if (addr == IF_ADDR) begin
            rdata = if_read;
        end else if (addr == IE_ADDR) begin
            rdata = ie_reg;
        end
    end

    irq_prio_enc #(
        .NUM_SRC(NUM_SRC)
    ) u_prio_enc (
        .req  (pending),
        .valid(enc_valid),
        .idx  (enc_idx)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enc_valid) state_next = PEND;
            PEND: begin
                if (irq_ack) begin
                    state_next = BLANK;
                end else if (!enc_valid) begin
                    state_next = IDLE;
                end
            end
            BLANK:   state_next = enc_valid ? PEND : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_reg        <= '0;
            ie_reg        <= 8'h00;
            state_reg     <= IDLE;
            irq_valid_reg <= 1'b0;
            irq_id_reg    <= 3'd0;
            irq_vec_reg   <= VEC_BASE;
        end else begin
            if_reg <= if_next;
            if (wr_ie) begin
                ie_reg <= wdata;
            end
            state_reg     <= state_next;
            irq_valid_reg <= (state_next == PEND);
            irq_id_reg    <= enc_idx;
            irq_vec_reg   <= vec_of(VEC_BASE, enc_idx);
        end
    end

    assign irq_valid = irq_valid_reg;
    assign irq_id    = irq_id_reg;
    assign irq_vec   = irq_vec_reg;

endmodule
